// File: rtl/prescale_pkg.sv
// Shared types and defaults for the multi-channel clock-enable prescaler.
package prescale_pkg;

    typedef enum logic [1:0] {
        PS_FREE    = 2'd0,
        PS_ONESHOT = 2'd1,
        PS_SYNC    = 2'd2,
        PS_OFF     = 2'd3
    } ps_mode_t;

    localparam int unsigned PS_W_DEF  = 16;
    localparam int unsigned PS_CH_DEF = 4;
    localparam int unsigned PS_MODE_W = 2;

endpackage

// File: rtl/prescale_ch.sv
// One prescaler channel: period counter, trigger edge detect and one-shot run flag.
module prescale_ch
    import prescale_pkg::*;
#(
    parameter int unsigned W = PS_W_DEF
) (
    input  logic         clk,
    input  logic         aclr_n,
    input  logic         sclr,
    input  logic         enable,
    input  ps_mode_t     mode,
    input  logic [W-1:0] T_scale,
    input  logic         trig,
    output logic         clk_ena,
    output logic         busy
);

    logic [W-1:0] r_cnt;
    logic         r_trig_q;
    ps_mode_t     r_mode_q;
    logic         r_run;
    logic         r_ena;

    logic [W-1:0] w_cnt_nxt;
    logic         w_run_nxt;
    logic         w_ena_nxt;
    logic         w_tedge;
    logic         w_cnt_zero;
    logic         w_idle;

    assign w_tedge    = trig & ~r_trig_q;
    assign w_cnt_zero = (r_cnt == '0);
    // A mode change costs one reload cycle so the new mode always starts from a full period.
    assign w_idle     = ~enable | (mode == PS_OFF) | (mode != r_mode_q);

    // Next-state rules, first match wins.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_run_nxt = r_run;
        w_ena_nxt = 1'b0;

        if (sclr) begin
            w_cnt_nxt = '0;
            w_run_nxt = 1'b0;
        end else if (w_idle) begin
            w_cnt_nxt = T_scale;
            w_run_nxt = 1'b0;
        end else begin
            case (mode)
                PS_FREE: begin
                    if (w_cnt_zero) begin
                        w_ena_nxt = 1'b1;
                        w_cnt_nxt = T_scale;
                    end else begin
                        w_cnt_nxt = r_cnt - W'(1);
                    end
                end
                PS_SYNC: begin
                    // Trigger wins over terminal count: re-phase without a strobe.
                    if (w_tedge) begin
                        w_cnt_nxt = T_scale;
                    end else if (w_cnt_zero) begin
                        w_ena_nxt = 1'b1;
                        w_cnt_nxt = T_scale;
                    end else begin
                        w_cnt_nxt = r_cnt - W'(1);
                    end
                end
                PS_ONESHOT: begin
                    if (w_tedge) begin
                        w_cnt_nxt = T_scale;
                        w_run_nxt = 1'b1;
                    end else if (r_run && w_cnt_zero) begin
                        w_ena_nxt = 1'b1;
                        w_run_nxt = 1'b0;
                        w_cnt_nxt = T_scale;
                    end else if (r_run) begin
                        w_cnt_nxt = r_cnt - W'(1);
                    end
                end
                PS_OFF: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_cnt    <= '0;
            r_trig_q <= 1'b0;
            r_mode_q <= PS_FREE;
            r_run    <= 1'b0;
            r_ena    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_trig_q <= trig;
            r_mode_q <= mode;
            r_run    <= w_run_nxt;
            r_ena    <= w_ena_nxt;
        end
    end

    assign clk_ena = r_ena;
    assign busy    = r_run;

endmodule

// File: rtl/prescale_mc.sv
// CH independent prescaler channels; the top only slices the flat ports per channel.
module prescale_mc
    import prescale_pkg::*;
#(
    parameter int unsigned CH = PS_CH_DEF,
    parameter int unsigned W  = PS_W_DEF
) (
    input  logic                      clk,
    input  logic                      aclr_n,
    input  logic                      sclr,
    input  logic [CH-1:0]             enable,
    input  logic [CH*PS_MODE_W-1:0]   mode,
    input  logic [CH*W-1:0]           T_scale,
    input  logic [CH-1:0]             trig,
    output logic [CH-1:0]             clk_ena,
    output logic [CH-1:0]             busy
);

    for (genvar g = 0; g < int'(CH); g++) begin : g_ch
        ps_mode_t w_mode;
        assign w_mode = ps_mode_t'(mode[g*PS_MODE_W +: PS_MODE_W]);

        prescale_ch #(
            .W (W)
        ) u_ch (
            .clk     (clk),
            .aclr_n  (aclr_n),
            .sclr    (sclr),
            .enable  (enable[g]),
            .mode    (w_mode),
            .T_scale (T_scale[g*W +: W]),
            .trig    (trig[g]),
            .clk_ena (clk_ena[g]),
            .busy    (busy[g])
        );
    end

endmodule

// File: tb/tb_prescale_mc.sv
// Self-checking bench for prescale_mc: directed scenarios plus random traffic against a cycle model.
module tb_prescale_mc;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;

    logic            clk = 1'b0;
    logic            aclr_n;
    logic            sclr;
    logic [CH-1:0]   enable;
    logic [2*CH-1:0] mode;
    logic [CH*W-1:0] t_scale;
    logic [CH-1:0]   trig;
    logic [CH-1:0]   clk_ena;
    logic [CH-1:0]   busy;

    always #5 clk = ~clk;

    prescale_mc #(.CH(CH), .W(W)) dut (
        .clk     (clk),
        .aclr_n  (aclr_n),
        .sclr    (sclr),
        .enable  (enable),
        .mode    (mode),
        .T_scale (t_scale),
        .trig    (trig),
        .clk_ena (clk_ena),
        .busy    (busy)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: remaining count, last trigger level, last mode, one-shot armed.
    int            m_cnt [CH];
    bit            m_tq  [CH];
    int            m_mq  [CH];
    bit            m_run [CH];
    logic [CH-1:0] exp_ena;
    logic [CH-1:0] exp_busy;

    function automatic int t_of(int c);
        return int'(t_scale[c*W +: W]);
    endfunction

    function automatic int md_of(int c);
        return int'(mode[2*c +: 2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < int'(CH); c++) begin
            m_cnt[c] = 0;
            m_tq[c]  = 1'b0;
            m_mq[c]  = 0;
            m_run[c] = 1'b0;
        end
        exp_ena  = '0;
        exp_busy = '0;
    endtask

    // Mode codes: 0 free, 1 one-shot, 2 sync, 3 off.
    task automatic model_edge();
        if (!aclr_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < int'(CH); c++) begin
            int md = md_of(c);
            int tv = t_of(c);
            bit te = trig[c] && !m_tq[c];
            exp_ena[c] = 1'b0;
            if (sclr) begin
                m_cnt[c] = 0;
                m_run[c] = 1'b0;
            end else if (!enable[c] || md == 3 || md != m_mq[c]) begin
                m_cnt[c] = tv;
                m_run[c] = 1'b0;
            end else if (md == 1) begin
                if (te) begin
                    m_cnt[c] = tv;
                    m_run[c] = 1'b1;
                end else if (m_run[c]) begin
                    if (m_cnt[c] == 0) begin
                        exp_ena[c] = 1'b1;
                        m_run[c]   = 1'b0;
                        m_cnt[c]   = tv;
                    end else begin
                        m_cnt[c] = m_cnt[c] - 1;
                    end
                end
            end else if (md == 2 && te) begin
                m_cnt[c] = tv;
            end else if (m_cnt[c] == 0) begin
                exp_ena[c] = 1'b1;
                m_cnt[c]   = tv;
            end else begin
                m_cnt[c] = m_cnt[c] - 1;
            end
            m_mq[c]     = md;
            m_tq[c]     = trig[c];
            exp_busy[c] = m_run[c];
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "/ena"},  32'(clk_ena), 32'(exp_ena));
        chk({tag, "/busy"}, 32'(busy),    32'(exp_busy));
    endtask

    task automatic set_ch(input int c, input bit en, input int md, input int tv);
        enable[c]        = en;
        mode[2*c +: 2]   = 2'(md);
        t_scale[c*W +: W] = W'(tv);
    endtask

    initial begin
        int nxt;
        int first;
        int bcnt;
        int nstb;
        int last [CH];
        int tv_f [CH];

        aclr_n  = 1'b0;
        sclr    = 1'b0;
        enable  = '0;
        trig    = '0;
        mode    = '0;
        t_scale = '0;
        model_reset();
        #12;
        chk("rst_ena",  32'(clk_ena), 32'd0);
        chk("rst_busy", 32'(busy),    32'd0);
        @(negedge clk);
        aclr_n = 1'b1;

        // Free-run T=4 after 3 disabled cycles: strobes on enabled edges 5,10,15,20.
        set_ch(0, 1'b0, 0, 4);
        repeat (3) step("A_dis");
        enable[0] = 1'b1;
        nxt = 5;
        for (int k = 1; k <= 20; k++) begin
            step("A");
            if (clk_ena[0] === 1'b1) begin
                chk("A_edge", 32'(k), 32'(nxt));
                nxt += 5;
            end
        end
        chk("A_count", 32'(nxt), 32'd25);

        // T changed 9->2 mid-count: strobes at 10, 13, 16.
        set_ch(0, 1'b0, 0, 9);
        step("B_dis");
        enable[0] = 1'b1;
        nxt = 10;
        for (int k = 1; k <= 18; k++) begin
            step("B");
            if (k == 4) set_ch(0, 1'b1, 0, 2);
            if (clk_ena[0] === 1'b1) begin
                chk("B_edge", 32'(k), 32'(nxt));
                nxt += 3;
            end
        end
        chk("B_count", 32'(nxt), 32'd19);

        // One-shot T=7: busy 8 cycles, single strobe 9 edges after trig rises.
        set_ch(0, 1'b0, 0, 0);
        set_ch(2, 1'b1, 1, 7);
        repeat (2) step("C_arm");
        trig[2] = 1'b1;
        bcnt = 0; first = 0; nstb = 0;
        for (int k = 1; k <= 12; k++) begin
            step("C");
            if (k == 1) trig[2] = 1'b0;
            if (busy[2] === 1'b1) bcnt++;
            if (clk_ena[2] === 1'b1) begin
                nstb++;
                if (first == 0) first = k;
            end
        end
        chk("C_busy_len", 32'(bcnt),  32'd8);
        chk("C_first",    32'(first), 32'd9);
        chk("C_nstrobe",  32'(nstb),  32'd1);

        // Retrigger with count at 3: strobe moves to 8 edges after the retrigger edge.
        trig[2] = 1'b1;
        first = 0; nstb = 0;
        for (int k = 1; k <= 20; k++) begin
            step("C_re");
            if (k == 1 || k == 6) trig[2] = 1'b0;
            if (k == 5) trig[2] = 1'b1;
            if (clk_ena[2] === 1'b1) begin
                nstb++;
                if (first == 0) first = k;
            end
        end
        chk("C_re_first",   32'(first), 32'd14);
        chk("C_re_nstrobe", 32'(nstb),  32'd1);

        // Sync T=5: trigger on the terminal-count edge suppresses the strobe.
        set_ch(2, 1'b0, 1, 7);
        set_ch(3, 1'b1, 2, 5);
        repeat (2) step("D_arm");
        for (int k = 0; k < 10; k++) begin
            if (m_cnt[3] == 0) break;
            step("D_wait");
        end
        trig[3] = 1'b1;
        step("D_coin");
        chk("D_nostrobe", 32'(clk_ena[3]), 32'd0);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            step("D");
            if (k == 1) trig[3] = 1'b0;
            if (clk_ena[3] === 1'b1 && first == 0) first = k;
        end
        chk("D_next", 32'(first), 32'd6);

        // Enable drop, sclr, mode change while running, async reset mid-count.
        set_ch(0, 1'b1, 0, 9);
        set_ch(1, 1'b1, 2, 3);
        set_ch(2, 1'b1, 1, 2);
        set_ch(3, 1'b1, 0, 6);
        repeat (7) step("E_run");
        enable[0] = 1'b0;
        step("E_dis");
        chk("E_dis_ena", 32'(clk_ena[0]), 32'd0);
        enable[0] = 1'b1;
        repeat (5) step("E_run2");
        sclr = 1'b1;
        step("E_sclr");
        chk("E_sclr_ena",  32'(clk_ena), 32'd0);
        chk("E_sclr_busy", 32'(busy),    32'd0);
        sclr = 1'b0;
        trig[2] = 1'b1;
        repeat (4) step("E_trig");
        trig[2] = 1'b0;
        mode[1:0] = 2'd2;
        repeat (12) step("E_mode");
        trig[2] = 1'b1;
        step("E_os");
        trig[2] = 1'b0;
        step("E_os2");
        aclr_n = 1'b0;
        #1;
        chk("E_aclr_ena",  32'(clk_ena), 32'd0);
        chk("E_aclr_busy", 32'(busy),    32'd0);
        model_reset();
        repeat (2) step("E_inrst");
        @(negedge clk);
        aclr_n = 1'b1;
        repeat (10) step("E_post");

        // Concurrent free-run with T = 0, 1, 254, 255: each gap must be exactly T+1.
        tv_f = '{0, 1, 254, 255};
        for (int c = 0; c < int'(CH); c++) begin
            set_ch(c, 1'b0, 0, tv_f[c]);
            last[c] = -1;
        end
        step("F_dis");
        enable = '1;
        for (int k = 1; k <= 600; k++) begin
            step("F");
            for (int c = 0; c < int'(CH); c++) begin
                if (clk_ena[c] === 1'b1) begin
                    if (last[c] >= 0) chk("F_gap", 32'(k - last[c]), 32'(tv_f[c] + 1));
                    last[c] = k;
                end
            end
        end
        chk("F_t0_last", 32'(last[0]), 32'd600);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < int'(CH); c++) begin
                if ($urandom_range(15) == 0) enable[c] = ~enable[c];
                if ($urandom_range(63) == 0) mode[2*c +: 2] = 2'($urandom_range(3));
                if ($urandom_range(31) == 0) t_scale[c*W +: W] = W'($urandom_range(11));
                if ($urandom_range(5) == 0)  trig[c] = ~trig[c];
            end
            sclr = ($urandom_range(99) == 0);
            step("G");
        end
        sclr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
